// File: rtl/hdmi_i2c_target.sv
// I2C responder standing in for the HDMI transmitter register port: 256x8 register
// file, auto-incrementing pointer, W1C interrupt status register driving int_n.
//
// state     | meaning
// IDLE      | bus free or reset, SDA released
// ADDR      | shifting in device address + R/W
// ADDR_ACK  | acknowledging our address
// PTR       | shifting in register pointer
// PTR_ACK   | acknowledging pointer byte
// WDATA     | shifting in write data
// WDATA_ACK | acknowledging write data
// RDATA     | shifting out reg[ptr]
// RDATA_ACK | SDA released, sampling master ACK/NACK
// IGNORE    | not addressed or read ended, wait for START/STOP
module hdmi_i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter logic [7:0] INT_REG  = 8'h96,
   parameter int         HPD_BIT  = 7
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       int_n,
   input  logic       hpd_evt,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t      state;
   logic [1:0]  scl_sync, sda_sync;
   logic        scl_prev, sda_prev;
   logic [2:0]  bit_cnt;
   logic        byte_done;
   logic        rw;
   logic [7:0]  shift;
   logic [7:0]  ptr;
   logic [7:0]  regs [256];
   logic [7:0]  int_next;

   logic scl, sda, scl_rise, scl_fall, start_det, stop_det, wr_en;
   logic [7:0] rx_byte;

   // Synchronizers reset to the idle-bus level so reset release cannot fake an edge
   always_ff @(posedge clk) begin
      if (!nrst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
         scl_prev <= scl_sync[1];
         sda_prev <= sda_sync[1];
      end
   end

   assign scl       = scl_sync[1];
   assign sda       = sda_sync[1];
   assign scl_rise  = scl & ~scl_prev;
   assign scl_fall  = ~scl & scl_prev;
   assign start_det = scl & scl_prev & ~sda & sda_prev;
   assign stop_det  = scl & scl_prev & sda & ~sda_prev;
   assign rx_byte   = {shift[6:0], sda};
   assign wr_en     = (state == WDATA) && scl_rise && (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         rw        <= 1'b0;
         shift     <= 8'h00;
         ptr       <= 8'h00;
         sda_oe    <= 1'b0;
      end else if (start_det || stop_det) begin
         state     <= start_det ? ADDR : IDLE;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         sda_oe    <= 1'b0;
      end else begin
         if (scl_rise && (state == ADDR || state == PTR || state == WDATA || state == RDATA)) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
               byte_done <= 1'b1;
         end
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift <= rx_byte;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        rw <= rx_byte[0];
                        if (rx_byte[7:1] != DEV_ADDR)
                           state <= IGNORE;
                     end else if (state == PTR) begin
                        ptr <= rx_byte;
                     end else begin
                        ptr <= ptr + 8'd1;
                     end
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done <= 1'b0;
                  sda_oe    <= 1'b1;
                  state     <= (state == ADDR) ? ADDR_ACK : (state == PTR) ? PTR_ACK : WDATA_ACK;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw) begin
                     shift  <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                     state  <= RDATA;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= PTR;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe <= 1'b0;
                  state  <= WDATA;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (byte_done) begin
                     byte_done <= 1'b0;
                     sda_oe    <= 1'b0;
                     state     <= RDATA_ACK;
                  end else begin
                     shift  <= {shift[6:0], 1'b0};
                     sda_oe <= ~shift[6];
                  end
               end
            end
            RDATA_ACK: begin
               // ptr advances on every ack slot, so a NACKed byte still counts as read
               if (scl_rise) begin
                  ptr <= ptr + 8'd1;
                  if (sda)
                     state <= IGNORE;
               end else if (scl_fall) begin
                  shift  <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                  state  <= RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      int_next = regs[INT_REG];
      if (wr_en && ptr == INT_REG)
         int_next = int_next & ~rx_byte;
      if (hpd_evt)
         int_next[HPD_BIT] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < 256; i++)
            regs[i] <= 8'h00;
         int_n <= 1'b1;
      end else begin
         if (wr_en && ptr != INT_REG)
            regs[ptr] <= rx_byte;
         regs[INT_REG] <= int_next;
         int_n         <= ~|regs[INT_REG];
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Bench for hdmi_i2c_target: bit-banged I2C master against a transaction-level
// register/pointer model, plus a vector table and hand-written corner sequences.
module tb_hdmi_i2c_target;
   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       hpd_evt = 1'b0;
   logic [7:0] dbg_addr = 8'h00;
   logic       sda_oe, int_n;
   logic [7:0] dbg_data;
   logic       sda_line;

   assign sda_line = m_sda & ~sda_oe;

   hdmi_i2c_target dut (
      .clk(clk), .nrst(nrst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .int_n(int_n), .hpd_evt(hpd_evt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] mregs [256];
   logic [7:0] mptr = 8'h00;
   logic [7:0] wq [$];

   // sda_oe must never move while SCL has been high for a while
   int  viol = 0;
   bit  saw_oe = 1'b0;
   logic oe_prev = 1'b0, scl_prev = 1'b1;
   always @(posedge clk) begin
      if (nrst && scl_prev && m_scl && sda_oe !== oe_prev) viol++;
      if (sda_oe) saw_oe = 1'b1;
      oe_prev  = sda_oe;
      scl_prev = m_scl;
   end

   initial begin
      #1500us;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
      if (a == 8'h96) mregs[a] = mregs[a] & ~d;
      else mregs[a] = d;
   endtask

   task automatic q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; q();
      m_scl = 1'b1; q();
      m_sda = 1'b0; q();
      m_scl = 1'b0; q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; q();
      m_scl = 1'b1; q();
      m_sda = 1'b1; q();
   endtask

   // with_hpd holds hpd_evt over the first three clk edges of the high phase
   task automatic wbit(input logic b, input bit with_hpd);
      m_sda = b; q();
      m_scl = 1'b1;
      if (with_hpd) begin
         hpd_evt = 1'b1;
         repeat (3) @(negedge clk);
         hpd_evt = 1'b0;
         repeat (2*Q-3) @(negedge clk);
      end else begin
         repeat (2*Q) @(negedge clk);
      end
      m_scl = 1'b0; q();
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1; q();
      m_scl = 1'b1; q();
      b = sda_line; q();
      m_scl = 1'b0; q();
   endtask

   task automatic wbyte(input logic [7:0] d, input bit hpd_last, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(d[i], hpd_last && i == 0);
      rbit(b);
      ack = ~b;
   endtask

   task automatic rbyte(input bit ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(~ack, 1'b0);
   endtask

   task automatic txn_write(input logic [7:0] p);
      logic a;
      i2c_start();
      wbyte(8'h72, 1'b0, a); chk("wr_addr_ack", a, 1);
      wbyte(p, 1'b0, a);     chk("wr_ptr_ack", a, 1);
      mptr = p;
      foreach (wq[i]) begin
         wbyte(wq[i], 1'b0, a); chk("wr_data_ack", a, 1);
         model_wr(mptr, wq[i]);
         mptr = mptr + 8'd1;
      end
      i2c_stop();
   endtask

   task automatic txn_read(input bit set_ptr, input logic [7:0] p, input int n);
      logic a;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         wbyte(8'h72, 1'b0, a); chk("rd_waddr_ack", a, 1);
         wbyte(p, 1'b0, a);     chk("rd_ptr_ack", a, 1);
         mptr = p;
         i2c_start();
      end
      wbyte(8'h73, 1'b0, a); chk("rd_addr_ack", a, 1);
      for (int k = 0; k < n; k++) begin
         rbyte(k != n-1, d);
         chk("rd_data", d, mregs[mptr]);
         mptr = mptr + 8'd1;
      end
      i2c_stop();
   endtask

   task automatic chk_dbg(input string name, input logic [7:0] a, input logic [7:0] exp);
      dbg_addr = a;
      @(negedge clk);
      chk(name, dbg_data, exp);
   endtask

   task automatic chk_int(input string name, input logic exp);
      repeat (2) @(negedge clk);
      chk(name, int_n, exp);
   endtask

   task automatic pulse_hpd();
      @(negedge clk) hpd_evt = 1'b1;
      @(negedge clk) hpd_evt = 1'b0;
      mregs[8'h96][7] = 1'b1;
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      bit         hpd;
      logic [7:0] exp_reg;
      logic       exp_int_n;
   } vec_t;
   vec_t tbl [8];

   initial begin
      logic a;
      logic [7:0] p;
      int n, kind;

      tbl[0] = '{8'h41, 8'h10, 1'b0, 8'h10, 1'b1};
      tbl[1] = '{8'hFF, 8'hA5, 1'b0, 8'hA5, 1'b1};
      tbl[2] = '{8'h96, 8'h00, 1'b1, 8'h80, 1'b0};
      tbl[3] = '{8'h96, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[4] = '{8'h96, 8'hFF, 1'b0, 8'h00, 1'b1};
      tbl[5] = '{8'h96, 8'h7F, 1'b1, 8'h80, 1'b0};
      tbl[6] = '{8'h96, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[7] = '{8'h00, 8'h3C, 1'b0, 8'h3C, 1'b1};
      foreach (mregs[i]) mregs[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_int_n", int_n, 1);
      chk_dbg("rst_reg96", 8'h96, 8'h00);
      nrst = 1'b1;
      repeat (4) @(negedge clk);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].hpd) pulse_hpd();
         wq = '{tbl[i].data};
         txn_write(tbl[i].addr);
         chk_dbg("tbl_reg", tbl[i].addr, tbl[i].exp_reg);
         chk_int("tbl_int_n", tbl[i].exp_int_n);
      end

      // Write, then combined read, then continued read proving the pointer
      wq = '{8'h10};
      txn_write(8'h41);
      chk_dbg("wr_0x41", 8'h41, 8'h10);
      wq = '{8'h5A, 8'h3C};
      txn_write(8'h42);
      txn_read(1'b1, 8'h41, 2);
      txn_read(1'b0, 8'h00, 1);

      // Address mismatch
      saw_oe = 1'b0;
      i2c_start();
      wbyte(8'h74, 1'b0, a); chk("mis_addr_nack", a, 0);
      wbyte(8'hAA, 1'b0, a); chk("mis_data_nack", a, 0);
      i2c_stop();
      chk("mis_no_oe", saw_oe, 0);
      chk_dbg("mis_reg41", 8'h41, 8'h10);
      chk_dbg("mis_regAA", 8'hAA, 8'h00);

      // Pointer wrap
      wq = '{8'hC3};
      txn_write(8'h01);
      wq = '{8'h11, 8'h22};
      txn_write(8'hFF);
      chk_dbg("wrap_regFF", 8'hFF, 8'h11);
      chk_dbg("wrap_reg00", 8'h00, 8'h22);
      txn_read(1'b0, 8'h00, 1);

      // Interrupt: set, one-clk int_n latency, clear, coincident set-vs-clear
      dbg_addr = 8'h96;
      @(negedge clk) hpd_evt = 1'b1;
      @(negedge clk) hpd_evt = 1'b0;
      mregs[8'h96] = 8'h80;
      chk("hpd_reg", dbg_data, 8'h80);
      chk("hpd_int_n_lat", int_n, 1);
      @(negedge clk);
      chk("hpd_int_n", int_n, 0);
      wq = '{8'h80};
      txn_write(8'h96);
      chk_dbg("clr_reg", 8'h96, 8'h00);
      chk_int("clr_int_n", 1'b1);
      i2c_start();
      wbyte(8'h72, 1'b0, a); chk("coin_addr_ack", a, 1);
      wbyte(8'h96, 1'b0, a); chk("coin_ptr_ack", a, 1);
      wbyte(8'h80, 1'b1, a); chk("coin_data_ack", a, 1);
      i2c_stop();
      mregs[8'h96] = 8'h80;
      mptr = 8'h97;
      chk_dbg("coin_reg", 8'h96, 8'h80);
      chk_int("coin_int_n", 1'b0);

      // STOP after four data bits discards the partial byte
      i2c_start();
      wbyte(8'h72, 1'b0, a); chk("abort_addr_ack", a, 1);
      wbyte(8'h50, 1'b0, a); chk("abort_ptr_ack", a, 1);
      mptr = 8'h50;
      for (int i = 0; i < 4; i++) wbit(1'b1, 1'b0);
      i2c_stop();
      chk("abort_sda_oe", sda_oe, 0);
      chk_dbg("abort_reg50", 8'h50, 8'h00);

      // Reset while the target drives ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) wbit(p_addr_bit(i), 1'b0);
      chk("ack_driven", sda_oe, 1);
      nrst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ack_sda_oe", sda_oe, 0);
      dbg_addr = 8'h41; #1;
      chk("rst_ack_reg41", dbg_data, 8'h00);
      foreach (mregs[i]) mregs[i] = 8'h00;
      mptr = 8'h00;
      @(negedge clk);
      nrst = 1'b1;
      chk_dbg("rst_ack_reg96", 8'h96, 8'h00);
      chk_int("rst_ack_int_n", 1'b1);
      i2c_stop();

      // Randomized transactions against the model
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 3);
         p = ($urandom_range(0, 7) == 0) ? 8'h96 : 8'($urandom);
         if (kind == 0) begin
            if ($urandom_range(0, 3) == 0) pulse_hpd();
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            txn_write(p);
            for (int k = 0; k < n; k++) chk_dbg("rnd_reg", p + 8'(k), mregs[p + 8'(k)]);
            chk_int("rnd_int_n", ~|mregs[8'h96]);
         end else begin
            txn_read(kind == 1, p, n);
         end
      end

      chk("oe_stable_scl_high", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   function automatic logic p_addr_bit(input int i);
      logic [7:0] w;
      w = 8'h72;
      return w[i];
   endfunction

endmodule
